// File: rtl/vr_ctrl_ws_pkg.sv
// Shared opcode and controller-state types for the VeriRisc-style sequencer.
// Used by vr_ctrl_ws (optional resume port: VR_CTRL_RESUME_EN).
package opcodes;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    DECODE     = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8,
    BUS_ERR    = 4'd9
  } ctrl_state_t;

  function automatic logic is_alu(opcode_t op);
    return (op == ADD) || (op == AND) ||
           (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/vr_wait_timer.sv
// Saturating memory-wait counter; expired flags the last allowed wait cycle.
// TIMEOUT=0 never expires.
module vr_wait_timer
  import opcodes::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          expired
);

  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT > 0) && (count == LAST);

endmodule

// File: rtl/vr_ctrl_ws.sv
// Multi-cycle CPU sequencer with memory wait states and bus timeout.
// Define VR_CTRL_RESUME_EN to add the resume port that leaves HALTED.
module vr_ctrl_ws
  import opcodes::*;
#(
  parameter int TIMEOUT = 15,
  parameter int OPW     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  opcode_t     opcode,
  input  logic        zero,
  input  logic        mem_ready,
`ifdef VR_CTRL_RESUME_EN
  input  logic        resume,
`endif
  output logic        halt,
  output logic        load_ac,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        inc_pc,
  output logic        load_pc,
  output logic        load_ir,
  output logic        bus_err,
  output ctrl_state_t state_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  if (OPW != $bits(opcode_t)) begin : g_opw_chk
    $error("OPW must equal the width of opcode_t");
  end

  ctrl_state_t   state;
  ctrl_state_t   state_n;
  logic          alu;
  logic          tmr_clr;
  logic [CW-1:0] tmr_count;
  logic          tmr_exp;

  assign alu     = is_alu(opcode);
  assign state_o = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INST_ADDR;
    else      state <= state_n;
  end

  // Counter restarts on every state change, so each wait starts at zero.
  assign tmr_clr = (state_n != state);

  vr_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (!tmr_clr),
    .count   (tmr_count),
    .expired (tmr_exp)
  );

  always_comb begin
    state_n = state;
    halt    = 1'b0;
    load_ac = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    load_ir = 1'b0;
    bus_err = 1'b0;
    unique case (state)
      INST_ADDR: state_n = INST_FETCH;
      INST_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready)    state_n = INST_LOAD;
        else if (tmr_exp) state_n = BUS_ERR;
      end
      INST_LOAD: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
        state_n = DECODE;
      end
      DECODE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
        state_n = OP_ADDR;
      end
      OP_ADDR: begin
        inc_pc  = 1'b1;
        state_n = (opcode == HLT) ? HALTED : OP_FETCH;
      end
      OP_FETCH: begin
        mem_rd = alu;
        if (!alu || mem_ready) state_n = ALU_OP;
        else if (tmr_exp)      state_n = BUS_ERR;
      end
      ALU_OP: begin
        mem_rd  = alu;
        load_ac = alu;
        load_pc = (opcode == JMP);
        inc_pc  = (opcode == SKZ) && zero;
        state_n = STORE;
      end
      STORE: begin
        mem_rd  = alu;
        load_ac = alu;
        load_pc = (opcode == JMP);
        mem_wr  = (opcode == STO);
        if ((opcode != STO) || mem_ready) state_n = INST_ADDR;
        else if (tmr_exp)                 state_n = BUS_ERR;
      end
      HALTED: begin
        halt = 1'b1;
`ifdef VR_CTRL_RESUME_EN
        if (resume) state_n = INST_ADDR;
`endif
      end
      BUS_ERR: bus_err = 1'b1;
      default: state_n = INST_ADDR;
    endcase
  end

endmodule

// File: tb/tb_vr_ctrl_ws.sv
// Directed bench for vr_ctrl_ws (TIMEOUT=4); honours VR_CTRL_RESUME_EN.
// Expected cycle counts and per-state strobe masks are hand-derived.
module tb_vr_ctrl_ws;
  import opcodes::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  opcode_t     opcode = ADD;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        resume = 1'b0;
  logic        halt, load_ac, mem_rd, mem_wr;
  logic        inc_pc, load_pc, load_ir, bus_err;
  ctrl_state_t state_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vr_ctrl_ws #(
    .TIMEOUT (4),
    .OPW     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
`ifdef VR_CTRL_RESUME_EN
    .resume    (resume),
`endif
    .halt      (halt),
    .load_ac   (load_ac),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .inc_pc    (inc_pc),
    .load_pc   (load_pc),
    .load_ir   (load_ir),
    .bus_err   (bus_err),
    .state_o   (state_o)
  );

  function automatic logic [7:0] outs();
    return {halt, load_ac, mem_rd, mem_wr,
            inc_pc, load_pc, load_ir, bus_err};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // result fields
  int          cyc, nrd, nwr, nopf_rd;
  logic [15:0] m_rd, m_wr, m_ac, m_ipc, m_lpc, m_ir;
  int          nboth;

  // Runs from the sampled INST_ADDR until back in INST_ADDR, HALTED or
  // BUS_ERR, stalling mem_ready for wf/wo/ws cycles in each wait state.
  task automatic run(input opcode_t op, input logic z,
                     input int wf, input int wo, input int ws);
    int s;
    opcode = op;
    zero = z;
    cyc = 0; nrd = 0; nwr = 0; nopf_rd = 0; nboth = 0;
    m_rd = '0; m_wr = '0; m_ac = '0;
    m_ipc = '0; m_lpc = '0; m_ir = '0;
    for (int k = 0; k < 40; k++) begin
      #0;
      s = int'(state_o);
      mem_ready = 1'b1;
      if (state_o == INST_FETCH && wf > 0) begin
        mem_ready = 1'b0; wf--;
      end
      if (state_o == OP_FETCH && wo > 0) begin
        mem_ready = 1'b0; wo--;
      end
      if (state_o == STORE && ws > 0) begin
        mem_ready = 1'b0; ws--;
      end
      if (mem_rd) begin nrd++; m_rd[s] = 1'b1; end
      if (mem_wr) begin nwr++; m_wr[s] = 1'b1; end
      if (mem_rd && mem_wr) nboth++;
      if (mem_rd && state_o == OP_FETCH) nopf_rd++;
      if (load_ac) m_ac[s] = 1'b1;
      if (inc_pc)  m_ipc[s] = 1'b1;
      if (load_pc) m_lpc[s] = 1'b1;
      if (load_ir) m_ir[s] = 1'b1;
      step();
      cyc++;
      if (state_o == INST_ADDR || state_o == HALTED ||
          state_o == BUS_ERR) break;
    end
    mem_ready = 1'b1;
  endtask

  initial begin
    #7;
    chk("rst_state", state_o, INST_ADDR);
    chk("rst_outs", outs(), 8'h00);
    opcode = STO;
    zero = 1'b1;
    #1;
    chk("rst_outs_sto", outs(), 8'h00);
    #4;
    rst = 1'b1;
    chk("release_state", state_o, INST_ADDR);

    // ADD, no waits: 8 cycles, 6 mem_rd
    run(ADD, 1'b0, 0, 0, 0);
    chk("add_cyc", cyc, 8);
    chk("add_rd", nrd, 6);
    chk("add_ac", m_ac, 16'h00C0);
    chk("add_ipc", m_ipc, 16'h0010);
    chk("add_ir", m_ir, 16'h000C);
    chk("add_wr", nwr, 0);
    chk("add_end", state_o, INST_ADDR);

    // LDA with 3 OP_FETCH wait cycles
    run(LDA, 1'b0, 0, 3, 0);
    chk("lda_cyc", cyc, 11);
    chk("lda_opf_rd", nopf_rd, 4);
    chk("lda_rd", nrd, 9);
    chk("lda_ac", m_ac, 16'h00C0);

    // XOR with 2 INST_FETCH wait cycles
    run(XOR, 1'b0, 2, 0, 0);
    chk("xor_cyc", cyc, 10);
    chk("xor_rd", nrd, 8);

    // SKZ with zero set / clear
    run(SKZ, 1'b1, 0, 0, 0);
    chk("skz1_cyc", cyc, 8);
    chk("skz1_ipc", m_ipc, 16'h0050);
    chk("skz1_rd", m_rd, 16'h000E);
    chk("skz1_ac", m_ac, 16'h0000);
    run(SKZ, 1'b0, 0, 0, 0);
    chk("skz0_ipc", m_ipc, 16'h0010);

    // JMP; non-ALU ops must not stall on mem_ready in OP_FETCH
    run(JMP, 1'b0, 0, 2, 0);
    chk("jmp_cyc", cyc, 8);
    chk("jmp_lpc", m_lpc, 16'h00C0);
    chk("jmp_rd", m_rd, 16'h000E);

    // STO with 2 STORE wait cycles
    run(STO, 1'b0, 0, 0, 2);
    chk("sto_cyc", cyc, 10);
    chk("sto_wr", nwr, 3);
    chk("sto_wr_m", m_wr, 16'h0080);
    chk("sto_rd", m_rd, 16'h000E);
    chk("sto_both", nboth, 0);

    // resume is ignored outside HALTED
    resume = 1'b1;
    run(ADD, 1'b0, 0, 0, 0);
    chk("res_ign_cyc", cyc, 8);
    resume = 1'b0;

    // HLT
    run(HLT, 1'b0, 0, 0, 0);
    chk("hlt_cyc", cyc, 5);
    chk("hlt_state", state_o, HALTED);
    chk("hlt_outs", outs(), 8'h80);
`ifdef VR_CTRL_RESUME_EN
    step();
    step();
    chk("hlt_hold", outs(), 8'h80);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume_state", state_o, INST_ADDR);
    chk("resume_outs", outs(), 8'h00);
`else
    for (int i = 0; i < 50; i++) begin
      step();
      chk("hlt_hold", outs(), 8'h80);
    end
    #2 rst = 1'b0;
    #1;
    chk("hlt_rst_state", state_o, INST_ADDR);
    chk("hlt_rst_outs", outs(), 8'h00);
    rst = 1'b1;
`endif

    // Timeout: mem_ready stuck low in INST_FETCH
    run(ADD, 1'b0, 100, 0, 0);
    chk("tmo_cyc", cyc, 5);
    chk("tmo_state", state_o, BUS_ERR);
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("tmo_hold", outs(), 8'h01);
      step();
    end
    #2 rst = 1'b0;
    #1;
    chk("tmo_rst_state", state_o, INST_ADDR);
    chk("tmo_rst_berr", bus_err, 1'b0);
    rst = 1'b1;

    // Normal operation after recovery
    run(AND, 1'b0, 0, 0, 0);
    chk("post_cyc", cyc, 8);
    chk("post_ac", m_ac, 16'h00C0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vr_ctrl_ws.md
VR_CTRL_WS -- requirements
Module: vr_ctrl_ws

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum memory wait cycles per access; 0 disables the timeout.
REQ-002 The block SHALL have parameter OPW, default 3, giving the opcode width; it SHALL equal the width of opcode_t.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port opcode, input, opcode_t (OPW bits): current IR opcode.
REQ-006 The block SHALL have port zero, input, 1 bit: accumulator-is-zero flag.
REQ-007 The block SHALL have port mem_ready, input, 1 bit: memory has completed the current rd/wr access this cycle.
REQ-008 The block SHALL have port resume, input, 1 bit, present only with VR_CTRL_RESUME_EN: leave the halted state.
REQ-009 The block SHALL have outputs halt, load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, bus_err, each 1 bit, each a control strobe.
REQ-010 The block SHALL have port state_o, output, ctrl_state_t: current state, for debug.

Function
REQ-011 The FSM SHALL have states INST_ADDR, INST_FETCH, INST_LOAD, DECODE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED, BUS_ERR.
REQ-012 Transitions SHALL be unconditional one-cycle steps, in the order of REQ-011, from INST_ADDR to STORE, and STORE SHALL return to INST_ADDR, except for the conditions in REQ-013 to REQ-016.
REQ-013 Wait states: the FSM SHALL hold in INST_FETCH, in OP_FETCH (ALU-class opcode only), and in STORE (STO only) while mem_ready=0; with mem_ready=1 in the first cycle there SHALL be zero added latency.
REQ-014 In OP_ADDR with opcode=HLT, the next state SHALL be HALTED, not OP_FETCH.
REQ-015 HALTED SHALL be held indefinitely; with VR_CTRL_RESUME_EN, resume=1 SHALL give next state INST_ADDR.
REQ-016 Timeout: the wait counter SHALL clear on entry to each wait state and increment each cycle in which the FSM holds; with TIMEOUT>0, mem_ready=0 while the counter equals TIMEOUT-1 SHALL give next state BUS_ERR.
REQ-017 BUS_ERR SHALL be sticky until reset.
REQ-018 ALU-class opcodes SHALL be ADD, AND, XOR, LDA.
REQ-019 The counter width SHALL be $clog2(TIMEOUT+1), and the counter SHALL saturate and never wrap.
REQ-020 Outputs SHALL be Moore/opcode-decoded combinational, 0 unless listed: INST_FETCH: mem_rd. INST_LOAD and DECODE: mem_rd, load_ir. OP_ADDR: inc_pc. OP_FETCH: mem_rd=alu. ALU_OP: mem_rd=alu, load_ac=alu, load_pc=(JMP), inc_pc=(SKZ && zero). STORE: mem_rd=alu, load_ac=alu, load_pc=(JMP), mem_wr=(STO). HALTED: halt. BUS_ERR: bus_err.
REQ-021 mem_wr and mem_rd SHALL never both be 1 in the same cycle.
REQ-022 Any undefined state encoding SHALL drive all strobes to 0 and give next state INST_ADDR.

Reset
REQ-023 When rst=0, the block SHALL asynchronously set state INST_ADDR and the wait counter to 0, and all outputs SHALL be 0.
REQ-024 Reset asserted mid-wait or in HALTED/BUS_ERR SHALL abort immediately; after release, fetch SHALL restart at INST_ADDR on the next rising edge.

Configuration
REQ-025 With VR_CTRL_RESUME_EN defined, the resume port SHALL exist and HALTED SHALL exit per REQ-015; resume SHALL be ignored in all other states.
REQ-026 With VR_CTRL_RESUME_EN undefined, the resume port SHALL be absent and HALTED SHALL be exitable only by reset.

Structure
REQ-027 ctrl_state_t (4-bit enum) and the ALU-class decode function SHALL live in the shared package opcodes, alongside opcode_t.
REQ-028 The wait/timeout counter SHALL be a sub-module vr_wait_timer (inputs clr, en; outputs count, expired).

Verification
REQ-029 Bench SHALL cover: reset release, ADD, mem_ready tied to 1 -> 8-cycle instruction; load_ac high in ALU_OP and STORE; mem_rd high 6 cycles.
REQ-030 Bench SHALL cover: LDA with mem_ready low 3 cycles in OP_FETCH -> instruction takes 11 cycles; mem_rd held throughout the wait.
REQ-031 Bench SHALL cover: TIMEOUT=4, mem_ready stuck 0 in INST_FETCH -> BUS_ERR after 4 cycles in INST_FETCH; bus_err=1 held 20 cycles; rst pulse -> INST_ADDR, bus_err=0.
REQ-032 Bench SHALL cover: HLT -> halt=1 from the cycle after OP_ADDR; with macro, resume=1 -> INST_ADDR next cycle; without macro, halt held 50 cycles.
REQ-033 Bench SHALL cover: SKZ with zero=1 -> inc_pc pulses in OP_ADDR and ALU_OP; with zero=0 -> pulse in OP_ADDR only; JMP -> load_pc in ALU_OP and STORE.
REQ-034 Bench SHALL cover: STO with mem_ready=0 for 2 cycles in STORE -> mem_wr high 3 cycles, mem_rd=0 throughout.
